// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 64-bit memory between the
// instruction-fetch requester and the data (load/store) requester.
// Data wins ties because it belongs to the older instruction; a run
// counter hands the port to fetch after MAX_DM_RUN back-to-back data
// grants so fetch always makes progress. A stalled memory is aborted
// after TIMEOUT cycles and the owner still gets its done pulse.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MAX_DM_RUN = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    // data requester
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [63:0]       dm_wdata,
    output logic [63:0]       dm_rdata,
    output logic              dm_done,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ack,
    // status
    output logic              busy,
    output logic              err
);

    localparam int RUN_W = (MAX_DM_RUN < 1) ? 1 : $clog2(MAX_DM_RUN + 1);
    localparam int TO_W  = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_DM = 1'b0,
        OWN_IF = 1'b1
    } owner_e;

    // Command as presented to memory; latched once at the grant edge so
    // requester-side changes cannot disturb an in-flight access.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       wdata;
    } mem_cmd_t;

    state_e           state_q, state_d;
    owner_e           owner_q;
    mem_cmd_t         cmd_q;
    logic [RUN_W-1:0] dm_run_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [TO_W-1:0]  to_inc;
    logic             abort_q;
    logic [31:0]      if_rdata_q;
    logic [63:0]      dm_rdata_q;

    logic starve;
    logic grant_dm;
    logic grant_if;
    logic ack_hit;
    logic to_hit;

    // Grant decision and ISSUE exit conditions
    always_comb begin
        starve   = if_req && (dm_run_q == RUN_MAX);
        grant_dm = (state_q == IDLE) && dm_req && !starve;
        grant_if = (state_q == IDLE) && if_req && !grant_dm;
        ack_hit  = (state_q == ISSUE) && mem_ack;
        to_inc   = to_cnt_q + TO_W'(1);
        // an ack in the last allowed cycle still wins over the abort
        to_hit   = (state_q == ISSUE) && !mem_ack && (to_inc == TO_MAX);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_dm || grant_if) state_d = ISSUE;
            ISSUE:   if (ack_hit || to_hit)    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Latch command and owner at the grant edge; fetches never write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_DM;
            cmd_q   <= '0;
        end else if (grant_dm) begin
            owner_q     <= OWN_DM;
            cmd_q.we    <= dm_we;
            cmd_q.addr  <= dm_addr;
            cmd_q.wdata <= dm_wdata;
        end else if (grant_if) begin
            owner_q     <= OWN_IF;
            cmd_q.we    <= 1'b0;
            cmd_q.addr  <= if_addr;
            cmd_q.wdata <= '0;
        end
    end

    // Count consecutive data grants taken while fetch was waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_run_q <= '0;
        end else if (grant_if) begin
            dm_run_q <= '0;
        end else if (grant_dm) begin
            if (!if_req)                dm_run_q <= '0;
            else if (dm_run_q != RUN_MAX) dm_run_q <= dm_run_q + RUN_W'(1);
        end
    end

    // Count unacknowledged ISSUE cycles; restarted for each new grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     to_cnt_q <= '0;
        else if (grant_dm || grant_if)                to_cnt_q <= '0;
        else if ((state_q == ISSUE) && !mem_ack)      to_cnt_q <= to_inc;
    end

    // Remember that the transaction now in RESP was aborted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) abort_q <= 1'b0;
        else      abort_q <= to_hit;
    end

    // Capture read data for the owner; an abort returns zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (ack_hit) begin
            if (owner_q == OWN_IF)
                if_rdata_q <= cmd_q.addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            else if (!cmd_q.we)
                dm_rdata_q <= mem_rdata;
        end else if (to_hit) begin
            if (owner_q == OWN_IF) if_rdata_q <= '0;
            else                   dm_rdata_q <= '0;
        end
    end

    // Outputs decode from registered state so reset clears them at once
    always_comb begin
        mem_req   = (state_q == ISSUE);
        mem_we    = cmd_q.we;
        mem_addr  = cmd_q.addr;
        mem_wdata = cmd_q.wdata;
        if_done   = (state_q == RESP) && (owner_q == OWN_IF);
        dm_done   = (state_q == RESP) && (owner_q == OWN_DM);
        err       = (state_q == RESP) && abort_q;
        busy      = (state_q != IDLE);
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
    end

    // Internal invariants
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(if_done && dm_done));
    a_err_done: assert property (@(posedge clk) disable iff (!rst)
        err |-> (if_done || dm_done));
    a_cmd_stable: assert property (@(posedge clk) disable iff (!rst)
        (mem_req && $past(mem_req)) |-> ($stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after the
// rising edge and outputs are sampled there too, so every check sees the
// settled post-edge state.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        err;

    int          total = 0;
    int          bad   = 0;
    logic        is_if;
    logic [63:0] rd;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .MAX_DM_RUN(4),
        .TIMEOUT   (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called while in ISSUE: hold off wait_cyc cycles, then ack for one cycle.
    // Returns 1 unit after the edge that enters RESP.
    task automatic ack(input int wait_cyc, input logic [63:0] data);
        repeat (wait_cyc) step();
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",   64'(mem_req),   64'h0);
        chk("rst_busy",      64'(busy),      64'h0);
        chk("rst_if_done",   64'(if_done),   64'h0);
        chk("rst_dm_done",   64'(dm_done),   64'h0);
        chk("rst_err",       64'(err),       64'h0);
        chk("rst_mem_we",    64'(mem_we),    64'h0);
        chk("rst_mem_addr",  64'(mem_addr),  64'h0);
        chk("rst_mem_wdata", mem_wdata,      64'h0);
        chk("rst_if_rdata",  64'(if_rdata),  64'h0);
        chk("rst_dm_rdata",  dm_rdata,       64'h0);
        rst = 1'b1;
        step();
        chk("rst_idle_busy", 64'(busy), 64'h0);

        // 1: fetch only, upper word selected by addr[2]
        if_req = 1'b1; if_addr = 32'h4;
        step();
        chk("t1_mem_req",  64'(mem_req),  64'h1);
        chk("t1_mem_we",   64'(mem_we),   64'h0);
        chk("t1_mem_addr", 64'(mem_addr), 64'h4);
        chk("t1_busy",     64'(busy),     64'h1);
        chk("t1_no_done",  64'(if_done),  64'h0);
        ack(1, 64'h1111_2222_3333_4444);
        chk("t1_if_done",  64'(if_done),  64'h1);
        chk("t1_if_rdata", 64'(if_rdata), 64'h1111_2222);
        chk("t1_dm_done",  64'(dm_done),  64'h0);
        chk("t1_err",      64'(err),      64'h0);
        chk("t1_resp_req", 64'(mem_req),  64'h0);
        if_req = 1'b0;
        step();
        chk("t1_idle_done", 64'(if_done), 64'h0);
        chk("t1_idle_busy", 64'(busy),    64'h0);

        // stray ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = '1;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("stray_busy",     64'(busy),     64'h0);
        chk("stray_if_done",  64'(if_done),  64'h0);
        chk("stray_if_rdata", 64'(if_rdata), 64'h1111_2222);
        step();
        chk("stray_after",    64'(if_done),  64'h0);

        // 2: simultaneous requests, data first, fetch in the next IDLE
        if_req = 1'b1; if_addr = 32'h8;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        step();
        chk("t2_first_addr", 64'(mem_addr), 64'h100);
        chk("t2_first_we",   64'(mem_we),   64'h0);
        ack(0, 64'hDEAD_BEEF_0000_0001);
        chk("t2_dm_done",    64'(dm_done),  64'h1);
        chk("t2_dm_rdata",   dm_rdata,      64'hDEAD_BEEF_0000_0001);
        chk("t2_if_wait",    64'(if_done),  64'h0);
        dm_req = 1'b0;
        step();
        chk("t2_idle_gap",   64'(busy),     64'h0);
        step();
        chk("t2_second_addr", 64'(mem_addr), 64'h8);
        ack(0, 64'h0123_4567_89AB_CDEF);
        chk("t2_if_done",    64'(if_done),  64'h1);
        chk("t2_if_rdata",   64'(if_rdata), 64'h89AB_CDEF);
        if_req = 1'b0;
        step();

        // 3: starvation guard, both requesters held continuously
        if_req = 1'b1; if_addr = 32'h4;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        for (int g = 0; g < 10; g++) begin
            is_if = (g == 4) || (g == 9);
            rd = {32'hAAAA_0000 + 32'(g), 32'h5555_0000 + 32'(g)};
            step();
            chk($sformatf("t3_g%0d_addr", g), 64'(mem_addr), is_if ? 64'h4 : 64'h300);
            ack(0, rd);
            chk($sformatf("t3_g%0d_if_done", g), 64'(if_done), 64'(is_if));
            chk($sformatf("t3_g%0d_dm_done", g), 64'(dm_done), 64'(!is_if));
            if (is_if)
                chk($sformatf("t3_g%0d_if_rdata", g), 64'(if_rdata), 64'(rd[63:32]));
            else
                chk($sformatf("t3_g%0d_dm_rdata", g), dm_rdata, rd);
            step();
        end
        if_req = 1'b0; dm_req = 1'b0;
        step();
        chk("t3_idle", 64'(busy), 64'h0);

        // 4: store, command latched and held until ack, dm_rdata untouched
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 64'hA5A5_A5A5_5A5A_5A5A;
        step();
        chk("t4_mem_we",    64'(mem_we),   64'h1);
        chk("t4_mem_addr",  64'(mem_addr), 64'h200);
        chk("t4_mem_wdata", mem_wdata,     64'hA5A5_A5A5_5A5A_5A5A);
        dm_addr = 32'h7F8; dm_wdata = '0;
        step();
        chk("t4_hold_req",   64'(mem_req),  64'h1);
        chk("t4_hold_addr",  64'(mem_addr), 64'h200);
        chk("t4_hold_wdata", mem_wdata,     64'hA5A5_A5A5_5A5A_5A5A);
        ack(1, 64'hFFFF_0000_FFFF_0000);
        chk("t4_dm_done",  64'(dm_done), 64'h1);
        chk("t4_dm_rdata", dm_rdata,     64'hAAAA_0008_5555_0008);
        chk("t4_err",      64'(err),     64'h0);
        dm_req = 1'b0; dm_we = 1'b0;
        step();

        // 5: timeout after 15 unacknowledged ISSUE cycles
        dm_req = 1'b1; dm_addr = 32'h180;
        step();
        repeat (14) step();
        chk("t5_still_issue", 64'(mem_req), 64'h1);
        chk("t5_no_err_yet",  64'(err),     64'h0);
        step();
        chk("t5_err",      64'(err),     64'h1);
        chk("t5_dm_done",  64'(dm_done), 64'h1);
        chk("t5_dm_rdata", dm_rdata,     64'h0);
        chk("t5_req_drop", 64'(mem_req), 64'h0);
        dm_req = 1'b0;
        step();
        chk("t5_err_clr",  64'(err),  64'h0);
        chk("t5_idle",     64'(busy), 64'h0);

        // 6: reset while in ISSUE, then a clean fetch
        if_req = 1'b1; if_addr = 32'hC;
        step();
        chk("t6_issue", 64'(mem_req), 64'h1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_req",    64'(mem_req),  64'h0);
        chk("t6_rst_busy",   64'(busy),     64'h0);
        chk("t6_rst_ifdone", 64'(if_done),  64'h0);
        chk("t6_rst_dmdone", 64'(dm_done),  64'h0);
        chk("t6_rst_rdata",  64'(if_rdata), 64'h0);
        step();
        rst = 1'b1;
        step();
        chk("t6_regrant_addr", 64'(mem_addr), 64'hC);
        chk("t6_regrant_req",  64'(mem_req),  64'h1);
        ack(0, 64'hCAFE_F00D_1234_5678);
        chk("t6_if_done",  64'(if_done),  64'h1);
        chk("t6_if_rdata", 64'(if_rdata), 64'hCAFE_F00D);
        chk("t6_err",      64'(err),      64'h0);
        if_req = 1'b0;
        step();
        chk("t6_idle", 64'(busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
